// File: rtl/rr_dispatch4.sv
// Single-entry dispatcher: one buffered word offered to one of four consumers,
// target chosen at load by strict round-robin or first-ready from the pointer.
module rr_dispatch4 #(
    parameter int DATA_W   = 8,
    parameter bit MODE_DEF = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        out_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic [7:0]        cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;

    logic              deliver;
    logic              load;
    logic [1:0]        ptr_eff;
    logic              mode_eff;
    logic [1:0]        target;

    assign deliver  = (state_q == FULL) && out_ready[sel_q];
    assign in_ready = en && !rst && ((state_q == EMPTY) || deliver);
    assign load     = in_valid && in_ready;

    // On a same-cycle deliver+load the search starts from the post-delivery pointer.
    assign ptr_eff  = deliver ? (sel_q + 2'd1) : ptr_q;
    assign mode_eff = load ? mode : mode_q;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        target = ptr_eff;
        found  = 1'b0;
        idx    = ptr_eff;
        if (mode_eff) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_eff + 2'(k);
                if (!found && out_ready[idx]) begin
                    target = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (deliver) begin
            ptr_d = sel_q + 2'd1;
            cnt_d = cnt_q + 8'd1;
        end
        if (load) begin
            state_d = FULL;
            data_d  = in_data;
            sel_d   = target;
            mode_d  = mode;
        end else if (deliver) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            mode_q  <= MODE_DEF;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = (state_q == FULL) ? (4'b0001 << sel_q) : 4'b0000;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_rr_dispatch4.sv
// Directed bench for rr_dispatch4: round-robin order, stalls, first-ready,
// back-to-back retargeting, enable gating, reset discard and counter wrap.
module tb_rr_dispatch4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic [7:0] cnt;

    int checks   = 0;
    int failures = 0;

    rr_dispatch4 #(.DATA_W(8), .MODE_DEF(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] v, input logic [7:0] d,
                             input logic [1:0] s, input logic [7:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},   32'(sel),       32'(s));
        check({tag, ".cnt"},   32'(cnt),       32'(c));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
        tick(); tick();
        check_out("reset", 4'b0000, 8'h00, 2'd0, 8'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; settle();
        check("release.in_ready", 32'(in_ready), 32'd1);

        // Strict round-robin, all ready, four back-to-back words
        out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'hA1; settle();
        tick(); check_out("rr0", 4'b0001, 8'hA1, 2'd0, 8'd0);
        in_data = 8'hA2; settle();
        check("rr.in_ready_full_deliver", 32'(in_ready), 32'd1);
        tick(); check_out("rr1", 4'b0010, 8'hA2, 2'd1, 8'd1);
        in_data = 8'hA3;
        tick(); check_out("rr2", 4'b0100, 8'hA3, 2'd2, 8'd2);
        in_data = 8'hA4;
        tick(); check_out("rr3", 4'b1000, 8'hA4, 2'd3, 8'd3);
        in_valid = 1'b0;
        tick(); check_out("rr_drain", 4'b0000, 8'hA4, 2'd3, 8'd4);

        // Mode 0 ignores out_ready: target is ptr=0 even though only consumer 1 is ready
        out_ready = 4'b0010; in_valid = 1'b1; in_data = 8'h55;
        tick(); check_out("stall_load", 4'b0001, 8'h55, 2'd0, 8'd4);
        in_data = 8'h66; settle();
        check("stall.in_ready", 32'(in_ready), 32'd0);
        tick(); check_out("stall_hold", 4'b0001, 8'h55, 2'd0, 8'd4);
        in_valid = 1'b0; out_ready = 4'b0011; settle();
        check("stall.in_ready_release", 32'(in_ready), 32'd1);
        tick(); check_out("stall_deliver", 4'b0000, 8'h55, 2'd0, 8'd5);
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h11;
        tick(); check_out("ptr_after_stall", 4'b0010, 8'h11, 2'd1, 8'd5);
        in_valid = 1'b0; out_ready = 4'b1111;
        tick(); check_out("ptr_drain", 4'b0000, 8'h11, 2'd1, 8'd6);

        // Reset while FULL and stalled discards the word
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h99;
        tick(); check_out("pre_reset_load", 4'b0100, 8'h99, 2'd2, 8'd6);
        in_valid = 1'b0; rst = 1'b1; settle();
        check("rst.in_ready", 32'(in_ready), 32'd0);
        tick(); check_out("mid_reset", 4'b0000, 8'h00, 2'd0, 8'd0);
        rst = 1'b0;

        // First-ready from ptr=0 with only consumer 2 ready
        mode = 1'b1; out_ready = 4'b0100; in_valid = 1'b1; in_data = 8'h33;
        tick(); in_valid = 1'b0;
        check_out("fr_load", 4'b0100, 8'h33, 2'd2, 8'd0);
        tick(); check_out("fr_deliver", 4'b0000, 8'h33, 2'd2, 8'd1);
        mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h44;
        tick(); check_out("ptr3_load", 4'b1000, 8'h44, 2'd3, 8'd1);

        // Deliver+load same cycle: search starts at sel+1 = 0, first ready is 1
        mode = 1'b1; out_ready = 4'b1010; in_data = 8'h45;
        tick(); check_out("b2b_retarget", 4'b0010, 8'h45, 2'd1, 8'd2);
        in_valid = 1'b0;
        tick(); check_out("b2b_drain", 4'b0000, 8'h45, 2'd1, 8'd3);
        out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h77;
        tick(); check_out("fr_none_ready", 4'b0100, 8'h77, 2'd2, 8'd3);

        // en low while FULL: held word still goes, nothing new accepted
        en = 1'b0; in_data = 8'h78; out_ready = 4'b0100; settle();
        check("en0.in_ready_full", 32'(in_ready), 32'd0);
        tick(); check_out("en0_deliver", 4'b0000, 8'h77, 2'd2, 8'd4);
        check("en0.in_ready_empty", 32'(in_ready), 32'd0);
        tick(); check_out("en0_no_accept", 4'b0000, 8'h77, 2'd2, 8'd4);
        en = 1'b1; in_valid = 1'b0;

        // 256 deliveries from reset wrap the counter
        rst = 1'b1; mode = 1'b0; out_ready = 4'b1111;
        tick(); rst = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 256; n++) begin
            in_data = 8'(n);
            tick();
            check("wrap.onehot0", 32'($onehot0(out_valid)), 32'd1);
            check("wrap.valid", 32'(out_valid), 32'(4'b0001 << (n % 4)));
        end
        check("wrap.cnt255", 32'(cnt), 32'd255);
        in_valid = 1'b0;
        tick();
        check_out("wrap_final", 4'b0000, 8'hFF, 2'd3, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
